// File: rtl/din_capture_pkg.sv
// Shared constants and types for the digital-input capture block.
package din_capture_pkg;

    localparam logic [3:0]  ADDR_MAIN    = 4'h0;
    // Chosen to stay clear of the DOUT control offset (0x1) in the same channel block.
    localparam logic [3:0]  OFF_DIN_CTRL = 4'h2;
    localparam logic [15:0] RUN_MAX      = 16'hFFFF;

    typedef struct packed {
        logic [15:0] high_time;
        logic [15:0] low_time;
    } cap_word_t;

    function automatic logic is_din_ctrl(input logic [7:0] addr_lo, input logic [3:0] chan);
        return (addr_lo[3:0] == OFF_DIN_CTRL) && (addr_lo[7:4] == chan);
    endfunction

endpackage

// File: rtl/din_capture_if.sv
// Main register bus as seen by the capture block.
interface din_capture_if;

    logic [15:0] reg_raddr;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic [31:0] reg_rdata;

    modport master (output reg_raddr, reg_waddr, reg_wdata, reg_wen, input reg_rdata);
    modport slave  (input reg_raddr, reg_waddr, reg_wdata, reg_wen, output reg_rdata);

endinterface

// File: rtl/din_capture_chan.sv
// One capture channel: synchronizer, glitch filter, run counter, width latches
// and stuck detection.
module din_capture_chan
    import din_capture_pkg::*;
#(
    parameter int unsigned FILT_CNT = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_din,
    input  logic      i_clr,
    output logic      o_filt,
    output cap_word_t o_word
);

    logic        r_s1, r_s2, r_filt, r_filt_d, r_primed;
    logic [15:0] r_run, r_high, r_low;
    logic        w_edge;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_din;
            r_s2 <= r_s1;
        end
    end

    if (FILT_CNT == 0) begin : g_nofilt
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) r_filt <= 1'b0;
            else       r_filt <= r_s2;
        end
    end else begin : g_filt
        localparam int unsigned FW = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
        localparam logic [FW-1:0] FCNT_LAST = FW'(FILT_CNT - 1);
        logic [FW-1:0] r_fcnt;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_fcnt <= '0;
                r_filt <= 1'b0;
            end else if (r_s2 != r_filt) begin
                if (r_fcnt == FCNT_LAST) begin
                    r_filt <= r_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_edge = r_filt ^ r_filt_d;

    // run holds the number of cycles the current level has been held so far,
    // so at the edge that ends a phase it equals that phase's width.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_filt_d <= 1'b0;
            r_primed <= 1'b0;
            r_run    <= '0;
            r_high   <= '0;
            r_low    <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (i_clr) begin
                r_high   <= '0;
                r_low    <= '0;
                r_primed <= 1'b0;
                r_run    <= 16'd1;
            end else if (w_edge) begin
                r_run    <= 16'd1;
                r_primed <= 1'b1;
                if (r_primed) begin
                    if (r_filt) r_low  <= r_run;
                    else        r_high <= r_run;
                end
            end else if (r_run != RUN_MAX) begin
                r_run <= r_run + 16'd1;
            end else if (r_filt) begin
                r_high <= RUN_MAX;
            end else begin
                r_low <= RUN_MAX;
            end
        end
    end

    assign o_filt = r_filt;
    assign o_word = {r_high, r_low};

endmodule

// File: rtl/din_capture.sv
// Digital-input capture top: per-channel capture units, clear decode and
// combinational register read mux.
module din_capture
    import din_capture_pkg::*;
#(
    parameter int unsigned NUM_DIN  = 4,
    parameter int unsigned FILT_CNT = 4
) (
    input  logic               sysclk,
    input  logic               reset,
    din_capture_if.slave       bus,
    input  logic [NUM_DIN-1:0] din,
    output logic [NUM_DIN-1:0] din_filt
);

    cap_word_t          w_word [NUM_DIN];
    logic [NUM_DIN-1:0] w_clr;
    logic               w_wr_main;
    logic               w_unused;

    assign w_wr_main = bus.reg_wen && (bus.reg_waddr[15:12] == ADDR_MAIN);
    assign w_unused  = ^{bus.reg_wdata, bus.reg_waddr[11:8], bus.reg_raddr[15:8]};

    // Register channel numbers start at 1; instance k serves channel k+1.
    for (genvar k = 0; k < NUM_DIN; k++) begin : g_chan
        assign w_clr[k] = w_wr_main && is_din_ctrl(bus.reg_waddr[7:0], 4'(k + 1));

        din_capture_chan #(
            .FILT_CNT(FILT_CNT)
        ) u_chan (
            .i_clk  (sysclk),
            .i_rst  (reset),
            .i_din  (din[k]),
            .i_clr  (w_clr[k]),
            .o_filt (din_filt[k]),
            .o_word (w_word[k])
        );
    end

    always_comb begin
        bus.reg_rdata = '0;
        for (int unsigned i = 0; i < NUM_DIN; i++) begin
            if (is_din_ctrl(bus.reg_raddr[7:0], 4'(i + 1))) bus.reg_rdata = w_word[i];
        end
    end

endmodule

// File: tb/tb_din_capture.sv
// Self-checking bench for din_capture: directed scenarios plus randomized
// multi-channel toggling against a phase-timing reference model.
module tb_din_capture;
    import din_capture_pkg::*;

    localparam int NCH = 4;
    localparam int FC  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] din;
    logic [NCH-1:0] din_filt;

    din_capture_if bus_if();

    din_capture #(.NUM_DIN(NCH), .FILT_CNT(FC)) dut (
        .sysclk   (clk),
        .reset    (rst),
        .bus      (bus_if),
        .din      (din),
        .din_filt (din_filt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned cyc      = 0;

    // Reference model: per channel, the current level and when it started
    // (in cycles of the raw input), edges seen since reset/clear, and widths.
    logic        mlev   [NCH];
    int unsigned tchg   [NCH];
    int unsigned edges  [NCH];
    logic [15:0] exp_hi [NCH];
    logic [15:0] exp_lo [NCH];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mlev[i]   = 1'b0;
            tchg[i]   = cyc;
            edges[i]  = 0;
            exp_hi[i] = '0;
            exp_lo[i] = '0;
        end
    endtask

    task automatic set_din(input logic [NCH-1:0] v);
        int unsigned L;
        logic [15:0] w;
        for (int i = 0; i < NCH; i++) begin
            if (v[i] != mlev[i]) begin
                L = cyc - tchg[i];
                w = (L >= 65535) ? 16'hFFFF : L[15:0];
                if (edges[i] != 0 || L >= 65535) begin
                    if (mlev[i]) exp_hi[i] = w;
                    else         exp_lo[i] = w;
                end
                edges[i]++;
                mlev[i] = v[i];
                tchg[i] = cyc;
            end
        end
        din = v;
    endtask

    task automatic set_bit(input int i, input logic b);
        logic [NCH-1:0] v;
        v    = din;
        v[i] = b;
        set_din(v);
    endtask

    function automatic logic [31:0] exp_word(input int i);
        logic [15:0] h, l;
        h = exp_hi[i];
        l = exp_lo[i];
        if (cyc - tchg[i] >= 65540) begin
            if (mlev[i]) h = 16'hFFFF;
            else         l = 16'hFFFF;
        end
        return {h, l};
    endfunction

    function automatic logic [NCH-1:0] exp_filt();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = mlev[i];
        return v;
    endfunction

    task automatic rd(input logic [3:0] chan, input logic [3:0] off, output logic [31:0] v);
        bus_if.reg_raddr = {ADDR_MAIN, 4'h0, chan, off};
        #1;
        v = bus_if.reg_rdata;
    endtask

    task automatic wr(input logic [3:0] top, input logic [3:0] chan, input logic [3:0] off);
        int c;
        bus_if.reg_waddr = {top, 4'h0, chan, off};
        bus_if.reg_wdata = $urandom;
        bus_if.reg_wen   = 1'b1;
        c = int'(chan);
        if (top == ADDR_MAIN && off == OFF_DIN_CTRL && c >= 1 && c <= NCH) begin
            exp_hi[c-1] = '0;
            exp_lo[c-1] = '0;
            edges[c-1]  = 0;
            tchg[c-1]   = cyc;
        end
        tick();
        bus_if.reg_wen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = '0;
        bus_if.reg_wen = 1'b0;
        tick(3);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        n_checks++;
        if (din_filt !== '0) $display("FAIL reset_filt: got %b expected 0", din_filt);
        else n_pass++;
        for (int k = 1; k <= NCH; k++) begin
            rd(4'(k), OFF_DIN_CTRL, v);
            n_checks++;
            if (v !== 32'd0) $display("FAIL reset_rd ch%0d: got %h expected 0", k, v);
            else n_pass++;
        end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        set_bit(0, 1'b1);
        tick(5);
        n_checks++;
        if (din_filt[0] !== 1'b0) $display("FAIL lag_early: got %b expected 0", din_filt[0]);
        else n_pass++;
        tick(1);
        n_checks++;
        if (din_filt[0] !== 1'b1) $display("FAIL lag_6: got %b expected 1", din_filt[0]);
        else n_pass++;
        tick(94);
        for (int p = 0; p < 2; p++) begin
            set_bit(0, 1'b0);
            tick(50);
            set_bit(0, 1'b1);
            if (p == 0) tick(100);
        end
        tick(10);
        rd(4'd1, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'h00640032) $display("FAIL periodic_const: got %h expected 00640032", v);
        else n_pass++;
        n_checks++;
        if (v !== exp_word(0)) $display("FAIL periodic_model: got %h expected %h", v, exp_word(0));
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        logic        seen;
        seen = 1'b0;
        din[1] = 1'b1;
        for (int t = 0; t < 3; t++) begin tick(); seen |= din_filt[1]; end
        din[1] = 1'b0;
        for (int t = 0; t < 10; t++) begin tick(); seen |= din_filt[1]; end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL glitch_filt: got rise expected none");
        else n_pass++;
        rd(4'd2, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL glitch_rd: got %h expected 0", v);
        else n_pass++;
        set_bit(1, 1'b1);
        tick(4);
        set_bit(1, 1'b0);
        tick(2);
        n_checks++;
        if (din_filt[1] !== 1'b1) $display("FAIL pulse4_filt: got %b expected 1", din_filt[1]);
        else n_pass++;
        tick(8);
        rd(4'd2, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'h00040000 || v !== exp_word(1))
            $display("FAIL pulse4_rd: got %h expected 00040000 (model %h)", v, exp_word(1));
        else n_pass++;
    endtask

    task automatic test_stuck();
        logic [31:0] v;
        set_bit(2, 1'b1);
        tick(70000);
        rd(4'd3, OFF_DIN_CTRL, v);
        n_checks++;
        if (v[31:16] !== 16'hFFFF) $display("FAIL stuck_high: got %h expected ffff", v[31:16]);
        else n_pass++;
        for (int k = 1; k <= NCH; k++) begin
            rd(4'(k), OFF_DIN_CTRL, v);
            n_checks++;
            if (v !== exp_word(k-1)) $display("FAIL stuck_model ch%0d: got %h expected %h", k, v, exp_word(k-1));
            else n_pass++;
        end
        set_bit(2, 1'b0);
        tick(10);
        rd(4'd3, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== exp_word(2) || v[31:16] !== 16'hFFFF)
            $display("FAIL stuck_nowrap: got %h expected %h", v, exp_word(2));
        else n_pass++;
    endtask

    task automatic test_clear();
        logic [31:0] v;
        do_reset();
        set_bit(0, 1'b1); tick(20);
        set_bit(0, 1'b0); tick(30);
        set_bit(0, 1'b1); tick(10);
        wr(ADDR_MAIN, 4'd1, OFF_DIN_CTRL);
        rd(4'd1, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL clear_next: got %h expected 0", v);
        else n_pass++;
        tick(10);
        set_bit(0, 1'b0); tick(25);
        rd(4'd1, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL clear_first_edge: got %h expected 0", v);
        else n_pass++;
        set_bit(0, 1'b1); tick(10);
        rd(4'd1, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'h00000019 || v !== exp_word(0))
            $display("FAIL clear_second_edge: got %h expected 00000019", v);
        else n_pass++;
        // Clear lands in the very cycle the filtered edge appears.
        set_bit(0, 1'b0);
        tick(6);
        wr(ADDR_MAIN, 4'd1, OFF_DIN_CTRL);
        tick(10);
        rd(4'd1, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL clear_on_edge: got %h expected 0", v);
        else n_pass++;
        set_bit(0, 1'b1); tick(12);
        set_bit(0, 1'b0); tick(10);
        rd(4'd1, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== exp_word(0) || v !== 32'h000C0000)
            $display("FAIL clear_after_edge: got %h expected 000c0000", v);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0]    v;
        logic [NCH-1:0] nv;
        int             rem [NCH];
        int             r0;
        logic [3:0]     top, chan, off;
        for (int r = 0; r < 10; r++) begin
            r0 = $urandom_range(4, 25);
            for (int i = 0; i < NCH; i++) rem[i] = (r % 2 == 0) ? r0 : $urandom_range(4, 25);
            for (int t = 0; t < 80; t++) begin
                nv = din;
                for (int i = 0; i < NCH; i++) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        nv[i]  = ~nv[i];
                        rem[i] = $urandom_range(4, 25) + i * 3;
                    end
                end
                set_din(nv);
                tick();
            end
            tick(10);
            top  = ($urandom_range(0, 3) == 0) ? 4'h5 : ADDR_MAIN;
            chan = 4'($urandom_range(0, 6));
            off  = ($urandom_range(0, 3) == 0) ? OFF_DIN_CTRL + 4'd1 : OFF_DIN_CTRL;
            wr(top, chan, off);
            n_checks++;
            if (din_filt !== exp_filt()) $display("FAIL rand_filt r%0d: got %b expected %b", r, din_filt, exp_filt());
            else n_pass++;
            for (int k = 1; k <= NCH; k++) begin
                rd(4'(k), OFF_DIN_CTRL, v);
                n_checks++;
                if (v !== exp_word(k-1)) $display("FAIL rand_rd r%0d ch%0d: got %h expected %h", r, k, v, exp_word(k-1));
                else n_pass++;
            end
        end
    endtask

    task automatic test_address();
        logic [31:0] v;
        logic [3:0]  chans [3];
        chans[0] = 4'd0;
        chans[1] = 4'(NCH + 1);
        chans[2] = 4'd15;
        for (int j = 0; j < 3; j++) begin
            rd(chans[j], OFF_DIN_CTRL, v);
            n_checks++;
            if (v !== 32'd0) $display("FAIL addr_chan%0d: got %h expected 0", chans[j], v);
            else n_pass++;
        end
        for (int k = 1; k <= NCH; k++) begin
            rd(4'(k), OFF_DIN_CTRL + 4'd1, v);
            n_checks++;
            if (v !== 32'd0) $display("FAIL addr_offset ch%0d: got %h expected 0", k, v);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        set_din('1);
        tick(12);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (din_filt !== '0) $display("FAIL async_filt: got %b expected 0", din_filt);
        else n_pass++;
        for (int k = 1; k <= NCH; k++) begin
            rd(4'(k), OFF_DIN_CTRL, v);
            n_checks++;
            if (v !== 32'd0) $display("FAIL async_rd ch%0d: got %h expected 0", k, v);
            else n_pass++;
        end
        din = '0;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(5);
        set_bit(3, 1'b1); tick(15);
        rd(4'd4, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL async_first_edge: got %h expected 0", v);
        else n_pass++;
        set_bit(3, 1'b0); tick(10);
        rd(4'd4, OFF_DIN_CTRL, v);
        n_checks++;
        if (v !== 32'h000F0000 || v !== exp_word(3))
            $display("FAIL async_second_edge: got %h expected 000f0000", v);
        else n_pass++;
    endtask

    initial begin
        rst              = 1'b1;
        din              = '0;
        bus_if.reg_raddr = '0;
        bus_if.reg_waddr = '0;
        bus_if.reg_wdata = '0;
        bus_if.reg_wen   = 1'b0;
        test_reset();
        test_periodic();
        test_glitch();
        test_stuck();
        test_clear();
        test_random();
        test_address();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
